// File: rtl/bpfcap_pkg.sv
// bpfcap_pkg: shared constants and types for the bpfcap packet-capture copy engine.
//   CSR word indices, control/status bit positions, and the copy FSM state enum.
package bpfcap_pkg;

  localparam logic [2:0] CSR_CONTROL   = 3'd0;
  localparam logic [2:0] CSR_PKT_BEGIN = 3'd1;
  localparam logic [2:0] CSR_PKT_END   = 3'd2;
  localparam logic [2:0] CSR_DST_BASE  = 3'd3;

  localparam int CTRL_BUSY_BIT = 0;
  localparam int CTRL_DONE_BIT = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/bpfcap_csr.sv
// bpfcap_csr: Avalon-MM slave register file for the copy engine.
//   Inputs : clk, reset, avs_s0_* (address/write/writedata/read), busy, done_set
//   Outputs: avs_s0_readdata (registered), pkt_begin, pkt_end, dst_base, start
//   Address registers are frozen while busy. done is sticky, W1C on control bit 1;
//   a set from the engine wins over a clear in the same cycle so completion is never lost.
module bpfcap_csr
  import bpfcap_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  avs_s0_address,
  input  logic        avs_s0_write,
  input  logic [31:0] avs_s0_writedata,
  input  logic        avs_s0_read,
  output logic [31:0] avs_s0_readdata,
  input  logic        busy,
  input  logic        done_set,
  output logic [31:0] pkt_begin,
  output logic [31:0] pkt_end,
  output logic [31:0] dst_base,
  output logic        start
);

  logic        done;
  logic [31:0] rd_mux;

  always_comb begin
    start = avs_s0_write && (avs_s0_address == CSR_PKT_END) && !busy;
  end

  always_comb begin
    rd_mux = '0;
    case (avs_s0_address)
      CSR_CONTROL: begin
        rd_mux[CTRL_BUSY_BIT] = busy;
        rd_mux[CTRL_DONE_BIT] = done;
      end
      CSR_PKT_BEGIN: rd_mux = pkt_begin;
      CSR_PKT_END:   rd_mux = pkt_end;
      CSR_DST_BASE:  rd_mux = dst_base;
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_begin       <= '0;
      pkt_end         <= '0;
      dst_base        <= '0;
      done            <= 1'b0;
      avs_s0_readdata <= '0;
    end else begin
      if (avs_s0_write && !busy) begin
        case (avs_s0_address)
          CSR_PKT_BEGIN: pkt_begin <= avs_s0_writedata;
          CSR_PKT_END:   pkt_end   <= avs_s0_writedata;
          CSR_DST_BASE:  dst_base  <= avs_s0_writedata;
          default: ;
        endcase
      end
      if (done_set) begin
        done <= 1'b1;
      end else if (avs_s0_write && (avs_s0_address == CSR_CONTROL)
                   && avs_s0_writedata[CTRL_DONE_BIT]) begin
        done <= 1'b0;
      end
      if (avs_s0_read) begin
        avs_s0_readdata <= rd_mux;
      end
    end
  end

endmodule

// File: rtl/bpfcap_top.sv
// bpfcap_top: packet-capture copy engine. Copies words pkt_begin..pkt_end-1 from the
//   read master (m0) to dst_base.. on the write master (m1), one word per cycle.
//   Inputs : clk, reset, avs_s0_* CSR slave, avs_m0_readdata
//   Outputs: avs_s0_readdata, avs_m0_read/address/burstcount,
//            avs_m1_write/address/writedata/burstcount
module bpfcap_top
  import bpfcap_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  avs_s0_address,
  input  logic        avs_s0_write,
  input  logic [31:0] avs_s0_writedata,
  input  logic        avs_s0_read,
  output logic [31:0] avs_s0_readdata,
  output logic        avs_m0_read,
  output logic [31:0] avs_m0_address,
  output logic [15:0] avs_m0_burstcount,
  input  logic [31:0] avs_m0_readdata,
  output logic        avs_m1_write,
  output logic [31:0] avs_m1_address,
  output logic [31:0] avs_m1_writedata,
  output logic [15:0] avs_m1_burstcount
);

  state_t      state, state_d;
  logic [31:0] pkt_begin, pkt_end, dst_base;
  logic        start, busy, done_set;
  logic [31:0] remaining, remaining_d;
  logic        m0_read_d, m1_write_d;
  logic [31:0] m0_addr_d, m1_addr_d, m1_data_d;

  assign avs_m0_burstcount = 16'd1;
  assign avs_m1_burstcount = 16'd1;
  assign busy              = (state != IDLE);

  bpfcap_csr u_csr (
    .clk              (clk),
    .reset            (reset),
    .avs_s0_address   (avs_s0_address),
    .avs_s0_write     (avs_s0_write),
    .avs_s0_writedata (avs_s0_writedata),
    .avs_s0_read      (avs_s0_read),
    .avs_s0_readdata  (avs_s0_readdata),
    .busy             (busy),
    .done_set         (done_set),
    .pkt_begin        (pkt_begin),
    .pkt_end          (pkt_end),
    .dst_base         (dst_base),
    .start            (start)
  );

  // remaining counts reads still to issue after the current one; the new pkt_end
  // comes straight from the bus because the CSR copy lands on the same edge.
  always_comb begin
    state_d     = state;
    remaining_d = remaining;
    m0_read_d   = avs_m0_read;
    m0_addr_d   = avs_m0_address;
    m1_write_d  = 1'b0;
    m1_addr_d   = avs_m1_address;
    m1_data_d   = avs_m1_writedata;
    done_set    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (avs_s0_writedata > pkt_begin) begin
            state_d     = RUN;
            m0_read_d   = 1'b1;
            m0_addr_d   = pkt_begin;
            remaining_d = avs_s0_writedata - pkt_begin - 32'd1;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      RUN: begin
        // Write offset equals the read offset of the word being sampled now.
        m1_write_d = 1'b1;
        m1_addr_d  = dst_base + (avs_m0_address - pkt_begin);
        m1_data_d  = avs_m0_readdata;
        if (remaining == 32'd0) begin
          m0_read_d = 1'b0;
          state_d   = DRAIN;
        end else begin
          m0_addr_d   = avs_m0_address + 32'd1;
          remaining_d = remaining - 32'd1;
        end
      end
      DRAIN: begin
        state_d  = IDLE;
        done_set = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      remaining        <= '0;
      avs_m0_read      <= 1'b0;
      avs_m0_address   <= '0;
      avs_m1_write     <= 1'b0;
      avs_m1_address   <= '0;
      avs_m1_writedata <= '0;
    end else begin
      state            <= state_d;
      remaining        <= remaining_d;
      avs_m0_read      <= m0_read_d;
      avs_m0_address   <= m0_addr_d;
      avs_m1_write     <= m1_write_d;
      avs_m1_address   <= m1_addr_d;
      avs_m1_writedata <= m1_data_d;
    end
  end

endmodule

// File: tb/tb_bpfcap_top.sv
// tb_bpfcap_top: directed bench for bpfcap_top. CSR behaviour from a vector table,
//   transfers stepped cycle by cycle against hand-derived timing.
//   Source memory model: word at address a holds a - 22 (so 0x20..0x27 -> 10..17).
module tb_bpfcap_top;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  avs_s0_address = '0;
  logic        avs_s0_write = 1'b0;
  logic [31:0] avs_s0_writedata = '0;
  logic        avs_s0_read = 1'b0;
  logic [31:0] avs_s0_readdata;
  logic        avs_m0_read;
  logic [31:0] avs_m0_address;
  logic [15:0] avs_m0_burstcount;
  logic [31:0] avs_m0_readdata;
  logic        avs_m1_write;
  logic [31:0] avs_m1_address;
  logic [31:0] avs_m1_writedata;
  logic [15:0] avs_m1_burstcount;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign avs_m0_readdata = avs_m0_read ? (avs_m0_address - 32'd22) : 32'hDEAD_BEEF;

  bpfcap_top dut (
    .clk               (clk),
    .reset             (reset),
    .avs_s0_address    (avs_s0_address),
    .avs_s0_write      (avs_s0_write),
    .avs_s0_writedata  (avs_s0_writedata),
    .avs_s0_read       (avs_s0_read),
    .avs_s0_readdata   (avs_s0_readdata),
    .avs_m0_read       (avs_m0_read),
    .avs_m0_address    (avs_m0_address),
    .avs_m0_burstcount (avs_m0_burstcount),
    .avs_m0_readdata   (avs_m0_readdata),
    .avs_m1_write      (avs_m1_write),
    .avs_m1_address    (avs_m1_address),
    .avs_m1_writedata  (avs_m1_writedata),
    .avs_m1_burstcount (avs_m1_burstcount)
  );

  typedef struct {
    logic        wr;
    logic        rd;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } csr_vec_t;

  csr_vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic csr_wr(input logic [2:0] addr, input logic [31:0] data);
    avs_s0_address   = addr;
    avs_s0_writedata = data;
    avs_s0_write     = 1'b1;
    tick();
    avs_s0_write     = 1'b0;
  endtask

  task automatic csr_rd_chk(input string name, input logic [2:0] addr, input logic [31:0] exp);
    avs_s0_address = addr;
    avs_s0_read    = 1'b1;
    tick();
    avs_s0_read    = 1'b0;
    chk(name, avs_s0_readdata, exp);
  endtask

  // Programs and starts a copy, then checks every cycle E+1..E+len+2.
  // poke_j > 0 writes pkt_begin=0x99 during that cycle; rst_j > 0 asserts reset
  // during that cycle and checks the masters go quiet.
  task automatic run_xfer(input logic [31:0] pb, input logic [31:0] pe,
                          input logic [31:0] dst, input int poke_j, input int rst_j);
    int len;
    len = (pe > pb) ? int'(pe - pb) : 0;
    csr_wr(3'd1, pb);
    csr_wr(3'd3, dst);
    csr_wr(3'd2, pe);
    for (int j = 1; j <= len + 2; j++) begin
      chk("m0_read", {31'd0, avs_m0_read}, {31'd0, (j <= len)});
      if (j <= len) chk("m0_address", avs_m0_address, pb + 32'(j - 1));
      chk("m1_write", {31'd0, avs_m1_write}, {31'd0, (j >= 2 && j <= len + 1)});
      if (j >= 2 && j <= len + 1) begin
        chk("m1_address", avs_m1_address, dst + 32'(j - 2));
        chk("m1_writedata", avs_m1_writedata, pb + 32'(j - 2) - 32'd22);
      end
      if (j == 1) begin
        avs_s0_address = 3'd0;
        avs_s0_read    = 1'b1;
      end
      if (j == poke_j) begin
        avs_s0_address   = 3'd1;
        avs_s0_writedata = 32'h99;
        avs_s0_write     = 1'b1;
      end
      if (j == rst_j) reset = 1'b1;
      tick();
      avs_s0_read  = 1'b0;
      avs_s0_write = 1'b0;
      if (j == 1) chk("busy_during_xfer", avs_s0_readdata, 32'd1);
      if (j == rst_j) begin
        for (int r = 0; r < 3; r++) begin
          chk("rst_m0_read", {31'd0, avs_m0_read}, 32'd0);
          chk("rst_m1_write", {31'd0, avs_m1_write}, 32'd0);
          if (r < 2) tick();
        end
        reset = 1'b0;
        for (int r = 0; r < 3; r++) begin
          tick();
          chk("post_rst_m1_write", {31'd0, avs_m1_write}, 32'd0);
          chk("post_rst_m0_read", {31'd0, avs_m0_read}, 32'd0);
        end
        return;
      end
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 3'd0, 32'h0,        32'h0};
    vecs[1]  = '{1'b1, 1'b0, 3'd0, 32'h0,        32'h0};
    vecs[2]  = '{1'b1, 1'b0, 3'd1, 32'h20,       32'h0};
    vecs[3]  = '{1'b0, 1'b1, 3'd1, 32'h0,        32'h20};
    vecs[4]  = '{1'b1, 1'b1, 3'd3, 32'h100,      32'h0};
    vecs[5]  = '{1'b0, 1'b1, 3'd3, 32'h0,        32'h100};
    vecs[6]  = '{1'b1, 1'b0, 3'd5, 32'hFFFF,     32'h100};
    vecs[7]  = '{1'b0, 1'b1, 3'd5, 32'h0,        32'h0};
    vecs[8]  = '{1'b0, 1'b1, 3'd7, 32'h0,        32'h0};
    vecs[9]  = '{1'b1, 1'b0, 3'd0, 32'hFFFFFFFD, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 3'd0, 32'h0,        32'h0};
    vecs[11] = '{1'b0, 1'b1, 3'd1, 32'h0,        32'h20};

    tick();
    tick();
    reset = 1'b0;
    chk("reset_readdata", avs_s0_readdata, 32'h0);
    chk("reset_m0_read", {31'd0, avs_m0_read}, 32'd0);
    chk("reset_m1_write", {31'd0, avs_m1_write}, 32'd0);
    chk("reset_m0_address", avs_m0_address, 32'h0);
    chk("reset_m1_address", avs_m1_address, 32'h0);
    chk("reset_m1_writedata", avs_m1_writedata, 32'h0);
    chk("m0_burstcount", {16'd0, avs_m0_burstcount}, 32'd1);
    chk("m1_burstcount", {16'd0, avs_m1_burstcount}, 32'd1);

    for (int i = 0; i < 12; i++) begin
      avs_s0_address   = vecs[i].addr;
      avs_s0_write     = vecs[i].wr;
      avs_s0_read      = vecs[i].rd;
      avs_s0_writedata = vecs[i].wdata;
      tick();
      avs_s0_write = 1'b0;
      avs_s0_read  = 1'b0;
      chk($sformatf("csr_vec%0d", i), avs_s0_readdata, vecs[i].exp_rdata);
    end

    // Main 8-word copy.
    run_xfer(32'h20, 32'h28, 32'h0, 0, 0);
    csr_rd_chk("done_after_xfer", 3'd0, 32'd2);
    csr_rd_chk("readback_begin", 3'd1, 32'h20);
    csr_rd_chk("readback_end", 3'd2, 32'h28);
    csr_wr(3'd0, 32'd0);
    csr_rd_chk("ctrl_write0_noeffect", 3'd0, 32'd2);
    csr_wr(3'd0, 32'd2);
    csr_rd_chk("done_cleared", 3'd0, 32'd0);

    // Zero-length: busy for one cycle, done on the next edge, no traffic.
    run_xfer(32'h30, 32'h30, 32'h0, 0, 0);
    csr_rd_chk("done_zero_len", 3'd0, 32'd2);
    csr_wr(3'd0, 32'd2);

    // pkt_end below pkt_begin behaves as zero length.
    run_xfer(32'h30, 32'h2F, 32'h0, 0, 0);
    csr_rd_chk("done_neg_len", 3'd0, 32'd2);
    csr_wr(3'd0, 32'd2);

    // Write to pkt_begin while busy is ignored.
    run_xfer(32'h20, 32'h24, 32'h40, 2, 0);
    csr_rd_chk("busy_write_ignored", 3'd1, 32'h20);
    csr_rd_chk("done_after_poke", 3'd0, 32'd2);
    csr_wr(3'd0, 32'd2);
    csr_rd_chk("done_cleared2", 3'd0, 32'd0);

    // Reset during cycle E+4 of an 8-word copy.
    run_xfer(32'h20, 32'h28, 32'h80, 0, 4);
    csr_rd_chk("rst_ctrl", 3'd0, 32'h0);
    csr_rd_chk("rst_begin", 3'd1, 32'h0);
    csr_rd_chk("rst_end", 3'd2, 32'h0);
    csr_rd_chk("rst_dst", 3'd3, 32'h0);
    chk("rst_m1_address", avs_m1_address, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
